// File: rtl/unit_tx_sched.sv
// Round-robin transmit scheduler: picks the next eligible computing unit for the
// packet transmitter, with per-unit credit tracking and a sticky protocol error.
module unit_tx_sched #(
  parameter  int N_UNITS = 4,
  parameter  int CREDITS = 2,
  localparam int UW      = (N_UNITS > 1) ? $clog2(N_UNITS) : 1,
  localparam int FW      = $clog2(N_UNITS * CREDITS + 1),
  localparam int CW      = $clog2(CREDITS + 1),
  localparam int LW      = $clog2(N_UNITS + 1)
) (
  input  logic               CORE_CLK,
  input  logic               RST_N,
  input  logic               req,
  output logic               grant,
  output logic [UW-1:0]      grant_unit,
  input  logic               tx_done,
  input  logic [N_UNITS-1:0] unit_ready,
  input  logic [N_UNITS-1:0] unit_tx_mask,
  input  logic [N_UNITS-1:0] unit_done,
  output logic [FW-1:0]      in_flight,
  output logic               no_unit,
  output logic               all_idle,
  output logic               err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_GRANT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [UW-1:0]   ptr_q, ptr_d;
  logic [LW-1:0]   lap_q, lap_d;
  logic            grant_q, grant_d;
  logic [UW-1:0]   grant_unit_q, grant_unit_d;
  logic            no_unit_q, no_unit_d;
  logic            err_q, err_d;
  logic [FW-1:0]   in_flight_q, in_flight_d;
  logic [CW-1:0]   credit_q [N_UNITS];
  logic [CW-1:0]   credit_d [N_UNITS];
  logic [N_UNITS-1:0] elig;
  logic            release_grant;

  function automatic logic [UW-1:0] wrap_inc(input logic [UW-1:0] p);
    return (p == UW'(N_UNITS - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < N_UNITS; i++) begin
      elig[i] = unit_ready[i] & ~unit_tx_mask[i] & (credit_q[i] != '0);
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    state_d       = state_q;
    ptr_d         = ptr_q;
    lap_d         = lap_q;
    grant_d       = grant_q;
    grant_unit_d  = grant_unit_q;
    no_unit_d     = no_unit_q;
    err_d         = err_q;
    release_grant = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) state_d = S_SEARCH;
      end
      S_SEARCH: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (elig[ptr_q]) begin
          grant_unit_d = ptr_q;
          grant_d      = 1'b1;
          lap_d        = '0;
          no_unit_d    = 1'b0;
          state_d      = S_GRANT;
        end else begin
          // One unit examined per cycle; a full fruitless lap flags no_unit.
          ptr_d = wrap_inc(ptr_q);
          if (lap_q == LW'(N_UNITS - 1)) begin
            lap_d     = '0;
            no_unit_d = 1'b1;
          end else begin
            lap_d = lap_q + 1'b1;
          end
        end
      end
      S_GRANT: begin
        if (tx_done) begin
          grant_d       = 1'b0;
          release_grant = 1'b1;
          ptr_d         = wrap_inc(grant_unit_q);
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (tx_done && (state_q != S_GRANT)) err_d = 1'b1;

    // Simultaneous consume and return on one unit cancel out.
    for (int i = 0; i < N_UNITS; i++) begin
      credit_d[i] = credit_q[i];
      if (unit_done[i] && !(release_grant && (grant_unit_q == UW'(i)))) begin
        if (credit_q[i] == CW'(CREDITS)) err_d = 1'b1;
        else                             credit_d[i] = credit_q[i] + 1'b1;
      end else if (!unit_done[i] && release_grant && (grant_unit_q == UW'(i))) begin
        credit_d[i] = credit_q[i] - 1'b1;
      end
    end

    in_flight_d = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      in_flight_d = in_flight_d + (FW'(CREDITS) - FW'(credit_q[i]));
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge CORE_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      lap_q        <= '0;
      grant_q      <= 1'b0;
      grant_unit_q <= '0;
      no_unit_q    <= 1'b0;
      err_q        <= 1'b0;
      in_flight_q  <= '0;
      // NOTE: the credit array is a small register file holding live state, so it is reset.
      for (int i = 0; i < N_UNITS; i++) credit_q[i] <= CW'(CREDITS);
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      lap_q        <= lap_d;
      grant_q      <= grant_d;
      grant_unit_q <= grant_unit_d;
      no_unit_q    <= no_unit_d;
      err_q        <= err_d;
      in_flight_q  <= in_flight_d;
      for (int i = 0; i < N_UNITS; i++) credit_q[i] <= credit_d[i];
    end
  end

  assign grant      = grant_q;
  assign grant_unit = grant_unit_q;
  assign in_flight  = in_flight_q;
  assign no_unit    = no_unit_q;
  assign err        = err_q;
  assign all_idle   = (state_q == S_IDLE) && (in_flight_q == '0);

endmodule

// File: tb/tb_unit_tx_sched.sv
// Bench for unit_tx_sched: table of grant transactions plus hand-written
// sequences for credit exhaustion, same-cycle credit traffic, errors and reset.
module tb_unit_tx_sched;

  localparam int N = 4;
  localparam int C = 2;

  logic       CORE_CLK = 1'b0;
  logic       RST_N;
  logic       req;
  logic       grant;
  logic [1:0] grant_unit;
  logic       tx_done;
  logic [3:0] unit_ready;
  logic [3:0] unit_tx_mask;
  logic [3:0] unit_done;
  logic [3:0] in_flight;
  logic       no_unit;
  logic       all_idle;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  unit_tx_sched #(.N_UNITS(N), .CREDITS(C)) dut (
    .CORE_CLK    (CORE_CLK),
    .RST_N       (RST_N),
    .req         (req),
    .grant       (grant),
    .grant_unit  (grant_unit),
    .tx_done     (tx_done),
    .unit_ready  (unit_ready),
    .unit_tx_mask(unit_tx_mask),
    .unit_done   (unit_done),
    .in_flight   (in_flight),
    .no_unit     (no_unit),
    .all_idle    (all_idle),
    .err         (err)
  );

  always #5 CORE_CLK = ~CORE_CLK;

  typedef struct {
    bit         new_test;
    logic [3:0] ready;
    logic [3:0] mask;
    int         exp_unit;
    int         exp_cycles;
    int         exp_in_flight;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CORE_CLK);
    #1;
  endtask

  task automatic do_reset();
    req       = 1'b0;
    tx_done   = 1'b0;
    unit_done = '0;
    RST_N     = 1'b0;
    #4;
    check("rst_grant",      32'(grant),      0);
    check("rst_grant_unit", 32'(grant_unit), 0);
    check("rst_in_flight",  32'(in_flight),  0);
    check("rst_all_idle",   32'(all_idle),   1);
    check("rst_no_unit",    32'(no_unit),    0);
    check("rst_err",        32'(err),        0);
    @(negedge CORE_CLK);
    RST_N = 1'b1;
    tick();
  endtask

  task automatic start_req(input int exp_unit);
    exp_q.push_back(exp_unit);
    req = 1'b1;
  endtask

  task automatic wait_grant(input string nm, input int max_cycles, output int cycles);
    int exp;
    cycles = 0;
    while (!grant && cycles < max_cycles) begin
      tick();
      cycles++;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    if (!grant) check({nm, "_timeout"}, 32'(grant), 1);
    else        check({nm, "_unit"}, 32'(grant_unit), 32'(exp));
  endtask

  task automatic finish_txn(input string nm);
    tx_done = 1'b1;
    req     = 1'b0;
    tick();
    tx_done = 1'b0;
    check({nm, "_grant_drop"}, 32'(grant), 0);
    tick();
  endtask

  initial begin
    int cyc;
    req = 1'b0; tx_done = 1'b0; unit_done = '0;
    unit_ready = 4'b1111; unit_tx_mask = 4'b0000;
    RST_N = 1'b1;
    #1;

    vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 0, 2, 1};
    vecs[1]  = '{1'b0, 4'b1111, 4'b0000, 1, 2, 2};
    vecs[2]  = '{1'b0, 4'b1111, 4'b0000, 2, 2, 3};
    vecs[3]  = '{1'b0, 4'b1111, 4'b0000, 3, 2, 4};
    vecs[4]  = '{1'b0, 4'b1111, 4'b0000, 0, 2, 5};
    vecs[5]  = '{1'b1, 4'b1011, 4'b0010, 0, 2, 1};
    vecs[6]  = '{1'b0, 4'b1011, 4'b0010, 3, 4, 2};
    vecs[7]  = '{1'b0, 4'b1011, 4'b0010, 0, 2, 3};
    vecs[8]  = '{1'b0, 4'b1011, 4'b0010, 3, 4, 4};
    vecs[9]  = '{1'b1, 4'b0001, 4'b0000, 0, 2, 1};
    vecs[10] = '{1'b0, 4'b0001, 4'b0000, 0, 5, 2};

    for (int v = 0; v < 11; v++) begin
      if (vecs[v].new_test) do_reset();
      unit_ready   = vecs[v].ready;
      unit_tx_mask = vecs[v].mask;
      start_req(vecs[v].exp_unit);
      wait_grant($sformatf("vec%0d", v), 20, cyc);
      check($sformatf("vec%0d_latency", v), 32'(cyc), 32'(vecs[v].exp_cycles));
      finish_txn($sformatf("vec%0d", v));
      check($sformatf("vec%0d_in_flight", v), 32'(in_flight), 32'(vecs[v].exp_in_flight));
    end

    // Unit 0 out of credit: a full lap raises no_unit, a returned credit recovers.
    start_req(0);
    for (int k = 0; k < 4; k++) tick();
    check("nu_before_lap", 32'(no_unit), 0);
    tick();
    check("nu_after_lap", 32'(no_unit), 1);
    check("nu_no_grant",  32'(grant),   0);
    unit_done = 4'b0001;
    tick();
    unit_done = 4'b0000;
    wait_grant("nu_regrant", 10, cyc);
    check("nu_cleared",   32'(no_unit),   0);
    check("nu_in_flight", 32'(in_flight), 1);
    finish_txn("nu");
    check("nu_in_flight_end", 32'(in_flight), 2);

    // Consume and return on unit 1 in the same cycle.
    do_reset();
    unit_ready = 4'b1111; unit_tx_mask = 4'b0001;
    start_req(1);
    wait_grant("same1", 10, cyc);
    check("same1_latency", 32'(cyc), 3);
    finish_txn("same1");
    check("same1_in_flight", 32'(in_flight), 1);
    unit_tx_mask = 4'b1101;
    start_req(1);
    wait_grant("same2", 10, cyc);
    check("same2_latency", 32'(cyc), 5);
    tx_done = 1'b1; unit_done = 4'b0010; req = 1'b0;
    tick();
    tx_done = 1'b0; unit_done = 4'b0000;
    check("same2_grant_drop", 32'(grant), 0);
    tick();
    tick();
    check("same2_in_flight", 32'(in_flight), 1);
    check("same2_err",       32'(err),       0);

    // Protocol errors are sticky until reset and leave credits alone.
    do_reset();
    unit_tx_mask = 4'b0000;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("err_tx_idle", 32'(err), 1);
    tick(); tick();
    check("err_sticky",       32'(err),       1);
    check("err_in_flight",    32'(in_flight), 0);
    check("err_all_idle",     32'(all_idle),  1);
    do_reset();
    unit_done = 4'b0100;
    tick();
    unit_done = 4'b0000;
    tick();
    check("err_overflow",           32'(err),       1);
    check("err_overflow_in_flight", 32'(in_flight), 0);

    // Reset during GRANT drops grant immediately and restores credits.
    do_reset();
    start_req(0);
    wait_grant("rg0", 10, cyc);
    finish_txn("rg0");
    start_req(1);
    wait_grant("rg1", 10, cyc);
    #2;
    RST_N = 1'b0;
    #1;
    check("rg_async_drop", 32'(grant), 0);
    req = 1'b0;
    @(negedge CORE_CLK);
    RST_N = 1'b1;
    tick();
    check("rg_in_flight", 32'(in_flight), 0);
    check("rg_all_idle",  32'(all_idle),  1);
    check("rg_err",       32'(err),       0);
    start_req(0);
    wait_grant("rg_ptr", 10, cyc);
    check("rg_ptr_latency", 32'(cyc), 2);
    finish_txn("rg_ptr");
    check("rg_ptr_in_flight", 32'(in_flight), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/unit_tx_sched.md
Name: unit_tx_sched

Overview:
- Round-robin scheduler that picks which computing unit receives the next candidate packet from the transmit arbiter.
- Tracks per-unit outstanding packets with credit counters, and skips units that are not ready, masked off or out of credit.
- Grants one unit at a time to the packet transmitter and holds the grant until the transmitter reports the packet is fully written.
- Sits in the CORE_CLK domain between the transmit arbiter's packet sender and the unit input ports.

Parameters:
- N_UNITS, 4: number of computing units; 1..64.
- CREDITS, 2: maximum packets in flight per unit; 1..15.

Ports:
- CORE_CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- req  in  1  level; the transmitter has a packet ready.
- grant  out  1  level; grant_unit is valid and may be written.
- grant_unit  out  `MSB(N_UNITS-1)+1  granted unit index.
- tx_done  in  1  pulse; the granted packet is fully written (last byte with ctrl).
- unit_ready  in  N_UNITS  unit input can accept a packet.
- unit_tx_mask  in  N_UNITS  1 = unit excluded from scheduling.
- unit_done  in  N_UNITS  pulse per unit; one result has been returned, so one credit is released.
- in_flight  out  `MSB(N_UNITS*CREDITS)+1  total outstanding packets.
- no_unit  out  1  a full lap found no eligible unit.
- all_idle  out  1  state IDLE and in_flight == 0.
- err  out  1  sticky protocol error.

Behaviour:
Reset (async, RST_N low):
- grant=0, grant_unit=0, round-robin pointer=0, state=IDLE.
- All credit[i]=CREDITS, in_flight=0, no_unit=0, err=0, lap counter=0.
- all_idle=1 (it is a combinational output).
- If reset is asserted during GRANT, grant drops immediately; an in-progress packet is abandoned and its credit is not consumed.

Eligibility:
- elig(i) = unit_ready[i] & ~unit_tx_mask[i] & (credit[i] != 0).
- Evaluated from inputs sampled at the current edge.

FSM states: IDLE, SEARCH, GRANT.
- IDLE: on req=1, go to SEARCH.
- SEARCH, req=0: go to IDLE; the pointer is kept.
- SEARCH, req=1 and elig(pointer): grant_unit<=pointer, grant<=1, go to GRANT; lap counter<=0, no_unit<=0.
- SEARCH, req=1 and not eligible: pointer<=pointer+1, wrapping N_UNITS-1 -> 0. The lap counter increments; when it reaches N_UNITS, no_unit<=1 and the counter resets to 0 while search continues. Exactly one unit is checked per cycle.
- GRANT: grant stays high and grant_unit stays stable until tx_done. req is ignored in this state.
- On tx_done in GRANT: grant<=0, credit[grant_unit] decrements, pointer<=grant_unit+1 (wrapped), go to IDLE.

Latency:
- req rises at edge t with the pointer unit eligible: SEARCH at t+1, grant=1 at t+2.
- Worst-case search is N_UNITS cycles after SEARCH is entered, provided some unit is eligible.

Credits:
- unit_done[i] increments credit[i].
- If a decrement (tx_done) and an increment (unit_done) hit the same unit in the same cycle, the credit is unchanged.
- unit_done[i] while credit[i]==CREDITS sets err; the credit stays saturated.
- Multiple unit_done bits may be set in one cycle; each is applied independently.

in_flight:
- Registered; equals sum over i of (CREDITS - credit[i]), one cycle after the credits change.

Errors:
- tx_done outside GRANT sets err and is otherwise ignored.
- err clears only on reset.

Masking:
- Changing unit_tx_mask during GRANT does not revoke the current grant.
- A masked unit's outstanding credits are still returned by unit_done.

Test Plan:
- N_UNITS=4, all ready, unmasked. Four req/tx_done transactions -> grant_unit sequence 0,1,2,3, then 0. grant rises 2 cycles after req. in_flight reaches 4.
- unit_tx_mask=4'b0010, unit_ready[2]=0 -> grants go to 0, 3, 0, 3. Each skipped unit costs one SEARCH cycle.
- CREDITS=2, only unit 0 eligible. Two grants; the third req stays in SEARCH, no_unit=1 after 4 cycles. A unit_done[0] pulse -> grant to unit 0 next check, no_unit returns to 0.
- tx_done and unit_done[1] on the same edge, granted unit 1 -> credit[1] unchanged, in_flight unchanged.
- tx_done in IDLE, or unit_done[2] with credit[2]=2 -> err=1, held until RST_N low. No credit change.
- RST_N low mid-GRANT -> grant=0 asynchronously. After release: pointer=0, all credits=2, in_flight=0, all_idle=1.
